wheel_encoder_decoder: RTL and testbench
========================================

Name: wheel_encoder_decoder

Overview:
Receives the quadrature feedback (A/B channels) from each wheel motor driven by the motor driver. It filters and decodes the feedback into a signed position count, a direction flag and a per-window speed value. It runs on the 1 MHz system clock and uses the 1 kHz prescaler output as a sampling-window strobe. Closed-loop duty control in the car top level consumes its outputs.

Parameters:
CNT_W, 16, width of position counter and speed output (signed, two's complement).
FILT_LEN, 4, consecutive identical synchronized samples required to accept a new A/B level (range 2..15).
WINDOW, 100, number of tick_1k strobes per speed measurement window (range 1..1023).

Ports:
clk  in  1  system clock (1 MHz domain)
rst  in  1  asynchronous, active-high reset
tick_1k  in  1  single-clk-wide strobe, one per ms, synchronous to clk
enc_a  in  1  raw encoder channel A, asynchronous
enc_b  in  1  raw encoder channel B, asynchronous
clr  in  1  synchronous clear of position, accumulator and window counter
position  out  CNT_W  signed accumulated step count
dir  out  1  last valid step direction, 1 = forward, 0 = reverse
speed  out  CNT_W  signed steps counted in the last completed window
speed_valid  out  1  one-clk pulse when speed is updated
err  out  1  one-clk pulse on an illegal transition (both channels changed)

Behaviour:
- Reset (async, rst=1): position=0, speed=0, speed_valid=0, err=0, dir=1. Synchronizers, filters, accumulator and window counter are cleared. FSM goes to INIT.
- Input path: each channel passes through a 2-flop synchronizer, then a per-channel stability counter. The filtered level takes the synchronized value only after FILT_LEN consecutive equal samples that differ from the current filtered level. Pulses shorter than FILT_LEN clk are discarded.
- Latency: position/dir/err update exactly FILT_LEN+3 clk edges after the first edge that samples a new raw level.
- FSM states:
  - INIT: wait until both filters report stable (FILT_LEN samples), load prev={A,B}, no count, then go to TRACK.
  - TRACK: normal decode.
  - rst forces INIT from any state. clr does not change the state.
- Decode (TRACK, on any filtered change, prev -> cur):
  - Forward sequence 00->01->11->10->00: position +1, dir=1.
  - Reverse sequence (opposite order): position -1, dir=0.
  - Both bits changed: err pulses for 1 clk, no count, dir unchanged, prev=cur.
  - No change: nothing happens.
- Position wraps modulo 2^CNT_W, so 0x7FFF+1 = 0x8000.
- Speed:
  - A signed accumulator of CNT_W+1 bits sums steps.
  - The window counter increments on tick_1k. On the WINDOW-th tick, speed takes the accumulator value, saturated to the signed CNT_W range. speed_valid pulses, the window counter returns to 0, and the accumulator reloads with the current cycle's step (0 or ±1) so that no step is lost.
  - Before the first completed window, speed stays 0.
- clr: position=0, accumulator=0, window counter=0. A step or tick in the same cycle is discarded. clr has priority over decode and window completion. speed and dir keep their values.
- Reset mid-window: the partial accumulation is lost and there is no speed_valid pulse.

Optional Feature:
Macro ENC_ERR_CNT_EN.
- Defined: adds output err_cnt[7:0], a saturating count (stops at 255) of err pulses. It is cleared by rst and by clr.
- Undefined: the port and counter are absent, and err still pulses.

Decomposition:
- Shared package: quadrature Gray-step constants (forward/reverse next-state encodings), the FSM state typedef (INIT, TRACK), and the DIR_FWD/DIR_REV constants shared with motor direction.
- One natural sub-module: enc_input_filter (2-flop sync plus FILT_LEN stability counter). It is instantiated once per channel.

Test Plan:
- Reset release, AB held at 10 for 20 clk, then 4 forward steps (10->00->01->11->10, each held 10 clk) -> no count from INIT; position=4, dir=1.
- From position=4, 6 reverse steps -> position=-2 (0xFFFE), dir=0, err never asserted.
- Glitch of 3 clk on enc_a with FILT_LEN=4 -> position unchanged, no err.
- AB jumps 00->11 held 10 clk -> err one-clk pulse, position and dir unchanged.
- WINDOW=2, 50 forward steps spread over 2 ticks -> speed=50, speed_valid pulse; a step on the completing tick cycle appears in the next window's speed.
- clr asserted in the same cycle as a forward step and the WINDOW-th tick -> position=0, no speed_valid; assert rst mid-window -> all outputs at reset values, dir=1.

Source files
------------

// File: rtl/wheel_encoder_decoder_pkg.sv
// Shared types and constants for the wheel encoder decoder: quadrature Gray-step
// encodings, tracking FSM states and motor direction values.
package wheel_encoder_decoder_pkg;

    typedef enum logic {StInit, StTrack} enc_state_e;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00; reverse walks it backwards.
    localparam logic [1:0] QUAD_FWD_FROM_00 = 2'b01;
    localparam logic [1:0] QUAD_FWD_FROM_01 = 2'b11;
    localparam logic [1:0] QUAD_FWD_FROM_11 = 2'b10;
    localparam logic [1:0] QUAD_FWD_FROM_10 = 2'b00;

    localparam logic [1:0] QUAD_REV_FROM_00 = 2'b10;
    localparam logic [1:0] QUAD_REV_FROM_10 = 2'b11;
    localparam logic [1:0] QUAD_REV_FROM_11 = 2'b01;
    localparam logic [1:0] QUAD_REV_FROM_01 = 2'b00;

    function automatic logic [1:0] quad_fwd_next(input logic [1:0] ab);
        logic [1:0] nxt;
        case (ab)
            2'b00:   nxt = QUAD_FWD_FROM_00;
            2'b01:   nxt = QUAD_FWD_FROM_01;
            2'b11:   nxt = QUAD_FWD_FROM_11;
            default: nxt = QUAD_FWD_FROM_10;
        endcase
        return nxt;
    endfunction

    function automatic logic [1:0] quad_rev_next(input logic [1:0] ab);
        logic [1:0] nxt;
        case (ab)
            2'b00:   nxt = QUAD_REV_FROM_00;
            2'b10:   nxt = QUAD_REV_FROM_10;
            2'b11:   nxt = QUAD_REV_FROM_11;
            default: nxt = QUAD_REV_FROM_01;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/wheel_encoder_decoder_filter.sv
// Per-channel input conditioning: 2-flop synchronizer followed by a stability
// counter that only accepts a new level after FILT_LEN consecutive equal samples.
module wheel_encoder_decoder_filter #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic stable
);

    localparam logic [3:0] LEN_LAST = 4'(FILT_LEN - 1);
    localparam logic [3:0] LEN_FULL = 4'(FILT_LEN);

    logic       sync1_q, sync2_q, level_q;
    logic [3:0] diff_cnt_q, eq_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            level_q    <= 1'b0;
            diff_cnt_q <= '0;
            eq_cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            if (sync2_q != level_q) begin
                eq_cnt_q <= '0;
                if (diff_cnt_q == LEN_LAST) begin
                    level_q    <= sync2_q;
                    diff_cnt_q <= '0;
                    // The accepted level was just seen FILT_LEN times in a row.
                    eq_cnt_q   <= LEN_FULL;
                end else begin
                    diff_cnt_q <= diff_cnt_q + 4'd1;
                end
            end else begin
                diff_cnt_q <= '0;
                if (eq_cnt_q != LEN_FULL) begin
                    eq_cnt_q <= eq_cnt_q + 4'd1;
                end
            end
        end
    end

    assign level  = level_q;
    assign stable = (eq_cnt_q == LEN_FULL);

endmodule

// File: rtl/wheel_encoder_decoder.sv
// Quadrature wheel encoder decoder: filtered A/B decode into position, direction and
// per-window speed. Optional ENC_ERR_CNT_EN adds a saturating illegal-transition counter.
module wheel_encoder_decoder
    import wheel_encoder_decoder_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned WINDOW   = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1k,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clr,
    output logic [CNT_W-1:0] position,
    output logic             dir,
    output logic [CNT_W-1:0] speed,
    output logic             speed_valid,
`ifdef ENC_ERR_CNT_EN
    output logic [7:0]       err_cnt,
`endif
    output logic             err
);

    localparam logic [9:0] WIN_LAST = 10'(WINDOW - 1);

    logic a_level, a_stable, b_level, b_stable;
    logic [1:0] cur_ab, prev_q;

    enc_state_e state_q, state_d;
    logic load_prev, step_fwd, step_rev, illegal;

    logic [CNT_W-1:0] position_q, speed_q, speed_sat;
    logic [CNT_W:0]   acc_q, acc_next, step_ext;
    logic [CNT_W+1:0] acc_sum;
    logic [9:0]       win_q;
    logic             dir_q, speed_valid_q, err_q;

    wheel_encoder_decoder_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk    (clk),
        .rst    (rst),
        .raw    (enc_a),
        .level  (a_level),
        .stable (a_stable)
    );

    wheel_encoder_decoder_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk    (clk),
        .rst    (rst),
        .raw    (enc_b),
        .level  (b_level),
        .stable (b_stable)
    );

    assign cur_ab = {a_level, b_level};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StInit:  if (a_stable && b_stable) state_d = StTrack;
            default: state_d = StTrack;
        endcase
    end

    always_comb begin
        load_prev = 1'b0;
        step_fwd  = 1'b0;
        step_rev  = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            StInit: load_prev = a_stable && b_stable;
            default: begin
                if (cur_ab != prev_q) begin
                    load_prev = 1'b1;
                    if (cur_ab == quad_fwd_next(prev_q)) begin
                        step_fwd = 1'b1;
                    end else if (cur_ab == quad_rev_next(prev_q)) begin
                        step_rev = 1'b1;
                    end else begin
                        illegal = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        step_ext = '0;
        if (step_fwd) begin
            step_ext = (CNT_W + 1)'(1);
        end else if (step_rev) begin
            step_ext = '1;
        end
        // Accumulator clamps at its own range instead of wrapping on very long windows.
        acc_sum  = {acc_q[CNT_W], acc_q} + {step_ext[CNT_W], step_ext};
        acc_next = acc_sum[CNT_W:0];
        if (acc_sum[CNT_W+1] != acc_sum[CNT_W]) begin
            acc_next = acc_sum[CNT_W+1] ? {1'b1, {CNT_W{1'b0}}} : {1'b0, {CNT_W{1'b1}}};
        end
        speed_sat = acc_q[CNT_W-1:0];
        if (acc_q[CNT_W] != acc_q[CNT_W-1]) begin
            speed_sat = acc_q[CNT_W] ? {1'b1, {(CNT_W-1){1'b0}}} : {1'b0, {(CNT_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q        <= 2'b00;
            err_q         <= 1'b0;
            position_q    <= '0;
            dir_q         <= DIR_FWD;
            speed_q       <= '0;
            speed_valid_q <= 1'b0;
            acc_q         <= '0;
            win_q         <= '0;
        end else begin
            if (load_prev) begin
                prev_q <= cur_ab;
            end
            err_q         <= illegal;
            speed_valid_q <= 1'b0;
            if (clr) begin
                position_q <= '0;
                acc_q      <= '0;
                win_q      <= '0;
            end else begin
                if (step_fwd) begin
                    position_q <= position_q + CNT_W'(1);
                    dir_q      <= DIR_FWD;
                end else if (step_rev) begin
                    position_q <= position_q - CNT_W'(1);
                    dir_q      <= DIR_REV;
                end
                if (tick_1k && (win_q == WIN_LAST)) begin
                    // This cycle's step opens the next window so it is never dropped.
                    speed_q       <= speed_sat;
                    speed_valid_q <= 1'b1;
                    acc_q         <= step_ext;
                    win_q         <= '0;
                end else begin
                    acc_q <= acc_next;
                    if (tick_1k) begin
                        win_q <= win_q + 10'd1;
                    end
                end
            end
        end
    end

`ifdef ENC_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (clr) begin
            err_cnt_q <= '0;
        end else if (illegal && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign position    = position_q;
    assign dir         = dir_q;
    assign speed       = speed_q;
    assign speed_valid = speed_valid_q;
    assign err         = err_q;

endmodule

// File: tb/tb_wheel_encoder_decoder.sv
// Directed bench for wheel_encoder_decoder: table of A/B steps plus hand sequences for
// latency, window completion, clr priority and mid-window reset.
module tb_wheel_encoder_decoder;

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned FILT_LEN = 4;
    localparam int unsigned WINDOW   = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tick_1k = 1'b0;
    logic             enc_a = 1'b1;
    logic             enc_b = 1'b0;
    logic             clr = 1'b0;
    logic [CNT_W-1:0] position, speed;
    logic             dir, speed_valid, err;

    int checks = 0;
    int errors = 0;
    int err_total = 0;
    int err_run = 0;
    int err_max = 0;
    int sv_total = 0;

    typedef struct {
        logic [1:0]  ab;
        logic        glitch;
        logic [15:0] pos;
        logic        dir;
        int          errs;
    } vec_t;

    vec_t vecs[13];

    wheel_encoder_decoder #(
        .CNT_W    (CNT_W),
        .FILT_LEN (FILT_LEN),
        .WINDOW   (WINDOW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1k     (tick_1k),
        .enc_a       (enc_a),
        .enc_b       (enc_b),
        .clr         (clr),
        .position    (position),
        .dir         (dir),
        .speed       (speed),
        .speed_valid (speed_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (err) begin
            err_total++;
            err_run++;
            if (err_run > err_max) err_max = err_run;
        end else begin
            err_run = 0;
        end
        if (speed_valid) sv_total++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_tick();
        tick_1k = 1'b1;
        cyc(1);
        tick_1k = 1'b0;
    endtask

    function automatic logic [1:0] fwd(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] rev(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    initial begin
        vecs[0]  = '{2'b00, 1'b0, 16'h0001, 1'b1, 0};
        vecs[1]  = '{2'b01, 1'b0, 16'h0002, 1'b1, 0};
        vecs[2]  = '{2'b11, 1'b0, 16'h0003, 1'b1, 0};
        vecs[3]  = '{2'b10, 1'b0, 16'h0004, 1'b1, 0};
        vecs[4]  = '{2'b11, 1'b0, 16'h0003, 1'b0, 0};
        vecs[5]  = '{2'b01, 1'b0, 16'h0002, 1'b0, 0};
        vecs[6]  = '{2'b00, 1'b0, 16'h0001, 1'b0, 0};
        vecs[7]  = '{2'b10, 1'b0, 16'h0000, 1'b0, 0};
        vecs[8]  = '{2'b11, 1'b0, 16'hFFFF, 1'b0, 0};
        vecs[9]  = '{2'b01, 1'b0, 16'hFFFE, 1'b0, 0};
        vecs[10] = '{2'b01, 1'b1, 16'hFFFE, 1'b0, 0};
        vecs[11] = '{2'b00, 1'b0, 16'hFFFD, 1'b0, 0};
        vecs[12] = '{2'b11, 1'b0, 16'hFFFD, 1'b0, 1};

        cyc(3);
        check("rst_position", position, 0);
        check("rst_dir", dir, 1);
        check("rst_speed", speed, 0);
        check("rst_speed_valid", speed_valid, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        cyc(20);
        check("init_no_count", position, 0);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].glitch) begin
                enc_a = ~enc_a;
                cyc(3);
                enc_a = ~enc_a;
            end else begin
                {enc_a, enc_b} = vecs[i].ab;
            end
            cyc(10);
            check($sformatf("vec%0d_pos", i), position, vecs[i].pos);
            check($sformatf("vec%0d_dir", i), dir, vecs[i].dir);
            check($sformatf("vec%0d_errs", i), err_total, vecs[i].errs);
        end
        check("err_pulse_width", err_max, 1);

        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(1);
        check("clr_pos", position, 0);
        check("clr_keeps_dir", dir, 0);
        check("clr_speed", speed, 0);

        // 50 forward steps across a two-tick window.
        for (int i = 1; i <= 50; i++) begin
            {enc_a, enc_b} = fwd({enc_a, enc_b});
            cyc(8);
            if (i == 25) pulse_tick();
        end
        cyc(4);
        pulse_tick();
        check("win1_speed", speed, 50);
        check("win1_valid", speed_valid, 1);
        check("win1_valid_count", sv_total, 1);
        check("win1_pos", position, 50);
        check("win1_dir", dir, 1);
        cyc(1);
        check("win1_valid_one_clk", speed_valid, 0);

        // Step landing on the completing tick belongs to the next window.
        pulse_tick();
        {enc_a, enc_b} = fwd({enc_a, enc_b});
        cyc(10);
        {enc_a, enc_b} = fwd({enc_a, enc_b});
        cyc(6);
        check("latency_before", position, 51);
        tick_1k = 1'b1;
        cyc(1);
        tick_1k = 1'b0;
        check("latency_after", position, 52);
        check("win2_speed", speed, 1);
        check("win2_valid", speed_valid, 1);
        cyc(10);
        {enc_a, enc_b} = fwd({enc_a, enc_b});
        cyc(10);
        pulse_tick();
        pulse_tick();
        check("win3_speed", speed, 2);
        check("win3_valid_count", sv_total, 3);

        // clr beats a simultaneous step and window-completing tick.
        pulse_tick();
        {enc_a, enc_b} = fwd({enc_a, enc_b});
        cyc(6);
        tick_1k = 1'b1;
        clr = 1'b1;
        cyc(1);
        tick_1k = 1'b0;
        clr = 1'b0;
        check("clr_prio_pos", position, 0);
        check("clr_prio_valid", speed_valid, 0);
        check("clr_prio_speed", speed, 2);
        check("clr_prio_valid_count", sv_total, 3);
        cyc(10);
        check("clr_step_dropped", position, 0);
        pulse_tick();
        cyc(1);
        check("clr_window_reset", sv_total, 3);

        // Reset in the middle of a window.
        {enc_a, enc_b} = rev({enc_a, enc_b});
        cyc(10);
        check("pre_rst_pos", position, 16'hFFFF);
        check("pre_rst_dir", dir, 0);
        rst = 1'b1;
        #1;
        check("midrst_pos", position, 0);
        check("midrst_dir", dir, 1);
        check("midrst_speed", speed, 0);
        check("midrst_valid", speed_valid, 0);
        check("midrst_err", err, 0);
        cyc(3);
        rst = 1'b0;
        cyc(20);
        check("post_rst_pos", position, 0);
        pulse_tick();
        check("post_rst_first_tick", sv_total, 3);
        pulse_tick();
        check("post_rst_valid_count", sv_total, 4);
        check("post_rst_speed", speed, 0);
        check("final_err_total", err_total, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
